// File: rtl/sysa_pkg.sv
// Shared defaults, feeder state encoding and drain length for the systolic array feeder.
package sysa_pkg;
  localparam int N_DEF  = 3;
  localparam int DW_DEF = 8;

  typedef logic [1:0] feed_state_t;
  localparam feed_state_t ST_IDLE   = 2'd0;
  localparam feed_state_t ST_STREAM = 2'd1;
  localparam feed_state_t ST_FLUSH  = 2'd2;

  // Zero vectors needed to push the last wavefront out of an N x N array.
  function automatic int drain_len(input int n);
    return 2 * n;
  endfunction
endpackage

// File: rtl/sysa_feeder_skew_line.sv
// Enable-gated delay line of DEPTH stages; one per feeder lane.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sysa_feeder.sv
// Input skew feeder: lane i delayed by i array steps, zero drain after the tile's last vector.
// Optional per-lane real-data tag on arr_vld when SYSA_FEED_VLD_EN is defined.
module sysa_feeder
  import sysa_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW*N-1:0] s_data,
  input  logic          s_last,
  output logic [DW*N-1:0] arr_in,
  output logic          arr_en,
  output logic          busy,
  output logic          done
`ifdef SYSA_FEED_VLD_EN
  ,
  output logic [N-1:0]  arr_vld
`endif
);
  localparam int DRAIN = drain_len(N);
  localparam int CW    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
`ifdef SYSA_FEED_VLD_EN
  localparam int LW = DW + 1;
`else
  localparam int LW = DW;
`endif

  feed_state_t state;
  logic [CW-1:0] cnt;
  logic acc, adv, flush, cnt_end;

  assign flush   = (state == ST_FLUSH);
  assign s_ready = !flush;
  assign acc     = s_valid & s_ready;
  assign adv     = acc | flush;
  assign arr_en  = adv;
  assign busy    = (state != ST_IDLE);
  assign cnt_end = (cnt == CW'(DRAIN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc) begin
            state <= s_last ? ST_FLUSH : ST_STREAM;
            cnt   <= '0;
          end
        end
        ST_STREAM: begin
          if (acc && s_last) begin
            state <= ST_FLUSH;
            cnt   <= '0;
          end
        end
        ST_FLUSH: begin
          if (cnt_end) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [N-1:0][LW-1:0] lane_d, lane_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    // Non-accepting advances (flush) inject zeros, tag included.
`ifdef SYSA_FEED_VLD_EN
    assign lane_d[i] = acc ? {1'b1, s_data[DW*i +: DW]} : '0;
    assign arr_vld[i] = lane_q[i][DW];
`else
    assign lane_d[i] = acc ? s_data[DW*i +: DW] : '0;
`endif
    assign arr_in[DW*i +: DW] = lane_q[i][DW-1:0];

    skew_line #(.DEPTH(i + 1), .W(LW)) u_line (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .d   (lane_d[i]),
      .q   (lane_q[i])
    );
  end
endmodule
